// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment scan decoder: segment table,
// special output codes, FSM state type and the anode index helper.
// Optional feature macro used by the decoder top: SEG7_DEC_DP_EN.
package seg7_pkg;

  localparam int SEG_ENTRIES = 17;
  localparam int MAX_DIGITS  = 32;

  localparam logic [4:0] CODE_BLANK   = 5'd16;
  localparam logic [4:0] CODE_INVALID = 5'd31;

  // Active-high segment patterns {a,b,c,d,e,f,g,dp}; index = hex value, 16 = blank.
  localparam logic [7:0] SEG_TABLE [SEG_ENTRIES] = '{
    8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
    8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h1A, 8'h7A, 8'hDE, 8'h8E,
    8'h00
  };

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    LOCKED = 2'd2
  } state_e;

  // Position of the low bit in an active-low one-hot select (caller pads unused bits with ones).
  function automatic int onehot_low_index(input logic [MAX_DIGITS-1:0] an_n_v);
    int idx = 0;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      if (!an_n_v[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational lookup of an active-high {a..g} pattern to a hex code,
// CODE_BLANK for all-off, CODE_INVALID when nothing in the table matches.
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] pattern_i,
  output logic [4:0] code_o
);

  // Table search; entries are unique so search order does not matter.
  always_comb begin
    code_o = CODE_INVALID;
    for (int i = 0; i < SEG_ENTRIES; i++) begin
      if (pattern_i == SEG_TABLE[i][7:1]) code_o = 5'(i);
    end
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Watches a multiplexed active-low 7-segment bus, waits for each digit to
// settle for STABLE_CYCLES samples, decodes it and hands it out on a
// valid/ready stream with frame tracking and a sticky overrun flag.
// Define SEG7_DEC_DP_EN to add the out_dp port and make dp part of settling.
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS    = 8,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [7:0]                    seg_n,
  input  logic [NUM_DIGITS-1:0]         an_n,
  input  logic                          out_ready,
  output logic                          out_valid,
  output logic [$clog2(NUM_DIGITS)-1:0] out_idx,
  output logic [4:0]                    out_code,
`ifdef SEG7_DEC_DP_EN
  output logic                          out_dp,
`endif
  output logic                          frame_done,
  output logic                          overrun
);

  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam int CNT_W = $clog2(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);
`ifdef SEG7_DEC_DP_EN
  localparam logic [7:0] KEY_MASK = 8'hFF;
`else
  localparam logic [7:0] KEY_MASK = 8'hFE;  // dp ignored for settling
`endif

  logic [7:0]            s_seg_q, p_seg_q;
  logic [NUM_DIGITS-1:0] s_an_q, p_an_q;
  state_e                state_q, state_d;
  logic [CNT_W-1:0]      stab_cnt_q, stab_cnt_d;
  logic                  captured_q, captured_d;
  logic [NUM_DIGITS-1:0] frame_mask_q, frame_mask_d, mask_set;
  logic                  out_valid_q, out_valid_d;
  logic [IDX_W-1:0]      out_idx_q, out_idx_d;
  logic [4:0]            out_code_q, out_code_d;
  logic                  frame_done_q, frame_done_d;
  logic                  overrun_q, overrun_d;
  logic                  out_dp_q, out_dp_d;

  logic [MAX_DIGITS-1:0] an_pad;
  logic [NUM_DIGITS-1:0] an_low;
  logic [IDX_W-1:0]      sel_idx;
  logic                  sel_valid, same, capture, accept;
  logic [4:0]            dec_code;

  seg7_pattern_decode u_decode (
    .pattern_i (~s_seg_q[7:1]),
    .code_o    (dec_code)
  );

  // Selection validity, selected index and stability against the previous sample.
  always_comb begin
    an_pad                 = '1;
    an_pad[NUM_DIGITS-1:0] = s_an_q;
    sel_idx                = IDX_W'(onehot_low_index(an_pad));
    an_low                 = ~s_an_q;
    sel_valid              = (an_low != '0) && ((an_low & (an_low - 1'b1)) == '0);
    same                   = (s_an_q == p_an_q) && ((s_seg_q & KEY_MASK) == (p_seg_q & KEY_MASK));
  end

  // Settle/lock state machine: counts identical samples, fires one capture per settled digit.
  always_comb begin
    state_d    = state_q;
    stab_cnt_d = stab_cnt_q;
    captured_d = captured_q;
    capture    = 1'b0;
    if (!sel_valid) begin
      state_d    = IDLE;
      stab_cnt_d = '0;
      captured_d = 1'b0;
    end else begin
      if (!same)                      stab_cnt_d = '0;
      else if (stab_cnt_q != CNT_MAX) stab_cnt_d = stab_cnt_q + 1'b1;
      unique case (state_q)
        IDLE:   state_d = SETTLE;
        SETTLE: begin
          if (same && (stab_cnt_q == CNT_MAX) && !captured_q) begin
            capture    = 1'b1;
            captured_d = 1'b1;
            state_d    = LOCKED;
          end
        end
        LOCKED: begin
          if (!same) begin
            captured_d = 1'b0;
            state_d    = SETTLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Output holding register, frame mask and overrun; a capture only lands if the slot is free.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_idx_d    = out_idx_q;
    out_code_d   = out_code_q;
    out_dp_d     = out_dp_q;
    frame_mask_d = frame_mask_q;
    frame_done_d = 1'b0;
    overrun_d    = overrun_q;
    accept       = capture && (!out_valid_q || out_ready);
    mask_set     = frame_mask_q | (NUM_DIGITS'(1) << sel_idx);
    if (accept) begin
      out_valid_d = 1'b1;
      out_idx_d   = sel_idx;
      out_code_d  = dec_code;
      out_dp_d    = ~s_seg_q[0];
      if (&mask_set) begin
        frame_done_d = 1'b1;
        frame_mask_d = '0;
      end else begin
        frame_mask_d = mask_set;
      end
    end else begin
      if (capture)                  overrun_d   = 1'b1;
      if (out_valid_q && out_ready) out_valid_d = 1'b0;
    end
  end

  // Input sampling stage plus one-cycle-delayed copy for stability comparison.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s_seg_q <= '1;
      s_an_q  <= '1;
      p_seg_q <= '1;
      p_an_q  <= '1;
    end else begin
      s_seg_q <= seg_n;
      s_an_q  <= an_n;
      p_seg_q <= s_seg_q;
      p_an_q  <= s_an_q;
    end
  end

  // FSM state, settle counter and captured flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      stab_cnt_q <= '0;
      captured_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      stab_cnt_q <= stab_cnt_d;
      captured_q <= captured_d;
    end
  end

  // Output stream, frame tracking and sticky overrun registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_idx_q    <= '0;
      out_code_q   <= '0;
      out_dp_q     <= 1'b0;
      frame_mask_q <= '0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_idx_q    <= out_idx_d;
      out_code_q   <= out_code_d;
      out_dp_q     <= out_dp_d;
      frame_mask_q <= frame_mask_d;
      frame_done_q <= frame_done_d;
      overrun_q    <= overrun_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_idx    = out_idx_q;
  assign out_code   = out_code_q;
  assign frame_done = frame_done_q;
  assign overrun    = overrun_q;
`ifdef SEG7_DEC_DP_EN
  assign out_dp     = out_dp_q;
`else
  logic unused_dp;
  assign unused_dp  = out_dp_q;
`endif

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Scoreboard bench for seg7_scan_decoder (NUM_DIGITS=8, STABLE_CYCLES=4).
// Expected {idx,code} pairs are queued when a digit is driven and popped on each handshake.
`timescale 1ns/1ps
module tb_seg7_scan_decoder;

  localparam int ND = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [7:0]    seg_n = 8'hFF;
  logic [ND-1:0] an_n = '1;
  logic          out_ready = 1'b0;
  logic          out_valid;
  logic [2:0]    out_idx;
  logic [4:0]    out_code;
  logic          frame_done;
  logic          overrun;
`ifdef SEG7_DEC_DP_EN
  logic          out_dp;
`endif

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] exp_q[$];  // {idx[2:0], code[4:0]}

  localparam logic [7:0] SEG_HI [17] = '{
    8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
    8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h1A, 8'h7A, 8'hDE, 8'h8E, 8'h00
  };

  seg7_scan_decoder #(.NUM_DIGITS(ND), .STABLE_CYCLES(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .seg_n      (seg_n),
    .an_n       (an_n),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .out_idx    (out_idx),
    .out_code   (out_code),
`ifdef SEG7_DEC_DP_EN
    .out_dp     (out_dp),
`endif
    .frame_done (frame_done),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({out_valid, frame_done, overrun, out_idx, out_code} !== 11'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got v=%b fd=%b ov=%b idx=%0d code=%0d, required all 0",
               out_valid, frame_done, overrun, out_idx, out_code);
    end
    $display("reset: outputs v=%b ov=%b idx=%0d code=%0d", out_valid, overrun, out_idx, out_code);
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    int seen = 0;
    logic [7:0] exp;
    out_ready = 1'b1;
    an_n = 8'hFE;
    seg_n = ~SEG_HI[3];
    exp_q.push_back({3'd0, 5'd3});
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        seen++;
        vectors++;
        if (i != 6) begin
          miscompares++;
          $display("FAIL single_latency: out_valid at cycle %0d, required cycle 6", i);
        end
        exp = exp_q.pop_front();
        vectors++;
        if ({out_idx, out_code} !== exp) begin
          miscompares++;
          $display("FAIL single_data: got idx=%0d code=%0d, required idx=%0d code=%0d",
                   out_idx, out_code, exp[7:5], exp[4:0]);
        end
        $display("single: cycle %0d idx=%0d code=%0d", i, out_idx, out_code);
      end
    end
    vectors++;
    if (seen != 1) begin
      miscompares++;
      $display("FAIL single_count: got %0d outputs, required 1", seen);
    end
  endtask

  task automatic test_overrun();
    logic [7:0] exp;
    out_ready = 1'b0;
    an_n = 8'hDF;
    seg_n = ~SEG_HI[10];
    exp_q.push_back({3'd5, 5'd10});
    repeat (20) @(negedge clk);
    vectors++;
    if ({out_valid, overrun, out_idx, out_code} !== {1'b1, 1'b0, 3'd5, 5'd10}) begin
      miscompares++;
      $display("FAIL overrun_hold: got v=%b ov=%b idx=%0d code=%0d, required v=1 ov=0 idx=5 code=10",
               out_valid, overrun, out_idx, out_code);
    end
    an_n = 8'hBF;
    seg_n = ~SEG_HI[1];
    repeat (8) @(negedge clk);
    vectors++;
    if ({out_valid, overrun, out_idx, out_code} !== {1'b1, 1'b1, 3'd5, 5'd10}) begin
      miscompares++;
      $display("FAIL overrun_drop: got v=%b ov=%b idx=%0d code=%0d, required v=1 ov=1 idx=5 code=10",
               out_valid, overrun, out_idx, out_code);
    end
    out_ready = 1'b1;
    vectors++;
    if (out_valid && out_ready && exp_q.size() != 0) begin
      exp = exp_q.pop_front();
      if ({out_idx, out_code} !== exp) begin
        miscompares++;
        $display("FAIL overrun_data: got idx=%0d code=%0d, required idx=%0d code=%0d",
                 out_idx, out_code, exp[7:5], exp[4:0]);
      end
    end else begin
      miscompares++;
      $display("FAIL overrun_handshake: got valid=%b queued=%0d, required valid=1 queued=1",
               out_valid, exp_q.size());
    end
    $display("overrun: held idx=%0d code=%0d ov=%b", out_idx, out_code, overrun);
    repeat (3) @(negedge clk);
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL overrun_no_recapture: got out_valid=%b, required 0", out_valid);
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    an_n = 8'h7F;
    seg_n = ~SEG_HI[9];
    repeat (7) @(negedge clk);
    vectors++;
    if (out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL midreset_pre: got out_valid=%b, required 1", out_valid);
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    vectors++;
    if ({out_valid, overrun, frame_done, out_idx, out_code} !== 11'd0) begin
      miscompares++;
      $display("FAIL midreset_clear: got v=%b ov=%b fd=%b idx=%0d code=%0d, required all 0",
               out_valid, overrun, frame_done, out_idx, out_code);
    end
    $display("midreset: v=%b ov=%b", out_valid, overrun);
    out_ready = 1'b1;
    an_n = 8'hFF;
    seg_n = 8'hFF;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_scan();
    int seen = 0;
    int fd_cnt = 0;
    int d, val;
    logic [7:0] exp;
    logic fd_exp;
    out_ready = 1'b1;
    for (int p = 0; p < 2; p++) begin
      for (int k = 0; k < 8; k++) begin
        d = (p == 0) ? k : 7 - k;
        val = (p == 0) ? k : 8 + k;
        an_n = ~(8'b1 << d);
        seg_n = ~SEG_HI[val];
        exp_q.push_back({3'(d), 5'(val)});
        for (int i = 1; i <= 6; i++) begin
          @(negedge clk);
          if (frame_done) fd_cnt++;
          if (out_valid && out_ready) begin
            seen++;
            exp = exp_q.pop_front();
            vectors++;
            if ({out_idx, out_code} !== exp) begin
              miscompares++;
              $display("FAIL scan_data: got idx=%0d code=%0d, required idx=%0d code=%0d",
                       out_idx, out_code, exp[7:5], exp[4:0]);
            end
            fd_exp = (p == 0) ? (exp[7:5] == 3'd7) : (exp[7:5] == 3'd0);
            vectors++;
            if (frame_done !== fd_exp) begin
              miscompares++;
              $display("FAIL scan_frame_done: idx=%0d got frame_done=%b, required %b",
                       out_idx, frame_done, fd_exp);
            end
`ifdef SEG7_DEC_DP_EN
            vectors++;
            if (out_dp !== 1'b0) begin
              miscompares++;
              $display("FAIL scan_dp: got out_dp=%b, required 0", out_dp);
            end
`endif
            $display("scan: pass %0d idx=%0d code=%0d frame_done=%b", p, out_idx, out_code, frame_done);
          end
        end
      end
    end
    vectors++;
    if (seen != 16 || fd_cnt != 2) begin
      miscompares++;
      $display("FAIL scan_counts: got outputs=%0d frame_done=%0d, required outputs=16 frame_done=2",
               seen, fd_cnt);
    end
  endtask

  task automatic test_invalid();
    int seen = 0;
    logic [7:0] exp;
    out_ready = 1'b1;
    an_n = 8'hFC;
    seg_n = ~SEG_HI[3];
    repeat (12) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    an_n = 8'hFF;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    vectors++;
    if (seen != 0) begin
      miscompares++;
      $display("FAIL invalid_select: got %0d outputs, required 0", seen);
    end
    for (int t = 0; t < 2; t++) begin
      an_n = (t == 0) ? 8'hFB : 8'hFD;
      seg_n = (t == 0) ? ~8'h02 : 8'hFF;
      exp_q.push_back((t == 0) ? {3'd2, 5'd31} : {3'd1, 5'd16});
      seen = 0;
      repeat (8) begin
        @(negedge clk);
        if (out_valid && out_ready) begin
          seen++;
          exp = exp_q.pop_front();
          vectors++;
          if ({out_idx, out_code} !== exp) begin
            miscompares++;
            $display("FAIL invalid_code: got idx=%0d code=%0d, required idx=%0d code=%0d",
                     out_idx, out_code, exp[7:5], exp[4:0]);
          end
          $display("invalid: idx=%0d code=%0d", out_idx, out_code);
        end
      end
      vectors++;
      if (seen != 1) begin
        miscompares++;
        $display("FAIL invalid_count: case %0d got %0d outputs, required 1", t, seen);
      end
    end
  endtask

  task automatic test_restart();
    int seen = 0;
    logic [7:0] exp;
    out_ready = 1'b1;
    an_n = 8'hF7;
    seg_n = ~SEG_HI[4];
    exp_q.push_back({3'd3, 5'd5});
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        seen++;
        vectors++;
        if (i != 9) begin
          miscompares++;
          $display("FAIL restart_latency: out_valid at cycle %0d, required cycle 9", i);
        end
        exp = exp_q.pop_front();
        vectors++;
        if ({out_idx, out_code} !== exp) begin
          miscompares++;
          $display("FAIL restart_data: got idx=%0d code=%0d, required idx=%0d code=%0d",
                   out_idx, out_code, exp[7:5], exp[4:0]);
        end
        $display("restart: cycle %0d idx=%0d code=%0d", i, out_idx, out_code);
      end
      if (i == 3) seg_n = ~SEG_HI[5];
    end
    vectors++;
    if (seen != 1) begin
      miscompares++;
      $display("FAIL restart_count: got %0d outputs, required 1", seen);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_overrun();
    test_reset_mid();
    test_scan();
    test_invalid();
    test_restart();
    repeat (4) @(negedge clk);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d pending, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
